// File: rtl/dmn_seq.sv
// Sequencer for the dmn_* parameter stage chain: enables stages in order,
// captures the addressed stage's parameters, stops on zero or on timeout.
module dmn_seq #(
  parameter int NSTAGE  = 4,
  parameter int IW      = 2,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [NSTAGE-1:0] stage_en,
  output logic [IW-1:0]     stage_idx,
  input  logic              stage_end,
  input  logic              stage_zero,
  input  logic [31:0]       para_in1,
  input  logic [31:0]       para_in2,
  input  logic [31:0]       para_in3,
  output logic              busy,
  output logic              done,
  output logic              early,
  output logic              timeout,
  output logic [IW-1:0]     res_stage,
  output logic [31:0]       res_para1,
  output logic [31:0]       res_para2,
  output logic [31:0]       res_para3
);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t        state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx_n, res_stage_n;
  logic          early_n, timeout_n;
  logic [31:0]   res_para1_n, res_para2_n, res_para3_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      stage_idx <= '0;
      stage_en  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      early     <= 1'b0;
      timeout   <= 1'b0;
      res_stage <= '0;
      res_para1 <= '0;
      res_para2 <= '0;
      res_para3 <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      stage_idx <= idx_n;
      // Outputs are decoded from the next state so they come straight off flops
      stage_en  <= (state_n == RUN) ? (NSTAGE'(1) << idx_n) : '0;
      busy      <= (state_n == RUN) || (state_n == GAP);
      done      <= (state_n == DONE);
      early     <= early_n;
      timeout   <= timeout_n;
      res_stage <= res_stage_n;
      res_para1 <= res_para1_n;
      res_para2 <= res_para2_n;
      res_para3 <= res_para3_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = stage_idx;
    early_n     = early;
    timeout_n   = timeout;
    res_stage_n = res_stage;
    res_para1_n = res_para1;
    res_para2_n = res_para2;
    res_para3_n = res_para3;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          early_n     = 1'b0;
          timeout_n   = 1'b0;
          res_stage_n = '0;
          res_para1_n = '0;
          res_para2_n = '0;
          res_para3_n = '0;
          idx_n       = '0;
          cnt_n       = '0;
          state_n     = RUN;
        end
      end
      RUN: begin
        // Abort beats a same-cycle end, and an end beats a same-cycle timeout
        if (abort) begin
          state_n = IDLE;
        end else if (stage_end) begin
          res_stage_n = stage_idx;
          res_para1_n = para_in1;
          res_para2_n = para_in2;
          res_para3_n = para_in3;
          if (stage_zero) begin
            early_n = 1'b1;
            state_n = DONE;
          end else if (stage_idx == IW'(NSTAGE - 1)) begin
            state_n = DONE;
          end else begin
            state_n = GAP;
          end
        end else if (cnt == TW'(TIMEOUT - 1)) begin
          timeout_n   = 1'b1;
          res_stage_n = stage_idx;
          state_n     = DONE;
        end else begin
          cnt_n = cnt + TW'(1);
        end
      end
      GAP: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          idx_n   = stage_idx + IW'(1);
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmn_seq.sv
// Testbench for dmn_seq: a simple stage bank with per-stage end latency and
// a trace-level reference model of the expected enable sequence and results.
module tb_dmn_seq;

  localparam int NSTAGE = 4;
  localparam int IW     = 2;
  localparam int TMO    = 8;
  localparam int TW     = 16;
  localparam int MAXC   = 60;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [NSTAGE-1:0] stage_en;
  logic [IW-1:0]     stage_idx;
  logic              stage_end;
  logic              stage_zero;
  logic [31:0]       para_in1, para_in2, para_in3;
  logic              busy, done, early, timeout;
  logic [IW-1:0]     res_stage;
  logic [31:0]       res_para1, res_para2, res_para3;

  // Stage bank: stage i ends lat[i] cycles after its enable rises
  int          lat  [NSTAGE];
  logic        zero [NSTAGE];
  logic [31:0] p1 [NSTAGE];
  logic [31:0] p2 [NSTAGE];
  logic [31:0] p3 [NSTAGE];
  int          age = 0;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [NSTAGE-1:0] exp_en[$];
  int                exp_done;
  logic              exp_early, exp_tmo;
  logic [IW-1:0]     exp_stage;
  logic [31:0]       exp_p1, exp_p2, exp_p3;

  logic [NSTAGE-1:0] obs_en[$];
  logic              obs_busy[$];
  int                obs_done;

  assign stage_end  = (stage_en != '0) && (age >= lat[stage_idx]);
  assign stage_zero = zero[stage_idx];
  assign para_in1   = p1[stage_idx];
  assign para_in2   = p2[stage_idx];
  assign para_in3   = p3[stage_idx];

  always @(posedge clk) begin
    if (stage_en == '0) age <= 0;
    else                age <= age + 1;
  end

  always #5 clk = ~clk;

  dmn_seq #(.NSTAGE(NSTAGE), .IW(IW), .TIMEOUT(TMO), .TW(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .stage_en(stage_en), .stage_idx(stage_idx),
    .stage_end(stage_end), .stage_zero(stage_zero),
    .para_in1(para_in1), .para_in2(para_in2), .para_in3(para_in3),
    .busy(busy), .done(done), .early(early), .timeout(timeout),
    .res_stage(res_stage),
    .res_para1(res_para1), .res_para2(res_para2), .res_para3(res_para3)
  );

  // Walk the stages at the level of "run cycles then one gap cycle"
  task automatic model();
    exp_en.delete();
    exp_early = 1'b0;
    exp_tmo   = 1'b0;
    exp_stage = '0;
    exp_p1 = '0; exp_p2 = '0; exp_p3 = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      logic [NSTAGE-1:0] v;
      int runs;
      v = '0;
      v[i] = 1'b1;
      runs = (lat[i] < TMO) ? lat[i] + 1 : TMO;
      repeat (runs) exp_en.push_back(v);
      exp_stage = IW'(i);
      if (lat[i] >= TMO) begin
        exp_tmo = 1'b1;
        break;
      end
      exp_p1 = p1[i]; exp_p2 = p2[i]; exp_p3 = p3[i];
      if (zero[i]) begin
        exp_early = 1'b1;
        break;
      end
      if (i == NSTAGE - 1) break;
      exp_en.push_back('0);
    end
    exp_done = exp_en.size() + 1;
  endtask

  // Pulse start, then record one sample per cycle until done or the budget runs out
  task automatic run_collect(input int abort_at, input int restart_at);
    obs_en.delete();
    obs_busy.delete();
    obs_done = -1;
    start = 1'b1;
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      obs_en.push_back(stage_en);
      obs_busy.push_back(busy);
      if (done) begin
        obs_done = c;
        break;
      end
      if (c == abort_at)   abort = 1'b1;
      if (c == restart_at) start = 1'b1;
    end
  endtask

  task automatic set_comb(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
    for (int i = 0; i < NSTAGE; i++) begin
      lat[i] = 0; zero[i] = 1'b0; p1[i] = a; p2[i] = b; p3[i] = d;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({stage_en, stage_idx, busy, done, early, timeout, res_stage} !== '0 ||
        {res_para1, res_para2, res_para3} !== '0)
      $display("[TB] FAIL reset: en=%b idx=%0d busy=%b done=%b early=%b tmo=%b rs=%0d p1=%h, want all 0",
               stage_en, stage_idx, busy, done, early, timeout, res_stage, res_para1);
    else pass_cnt++;
  endtask

  task automatic test_chain();
    set_comb(32'hff9911, 32'hff9912, 32'hff9918);
    model();
    run_collect(-1, -1);
    for (int k = 0; k < exp_en.size() && k < obs_en.size(); k++) begin
      total_cnt++;
      if (obs_en[k] !== exp_en[k])
        $display("[TB] FAIL chain_en cycle %0d: got %b want %b", k + 1, obs_en[k], exp_en[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_done !== 8) $display("[TB] FAIL chain_done_cycle: got %0d want 8", obs_done);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (res_stage !== 2'd3 || res_para1 !== 32'hff9911 || res_para3 !== 32'hff9918 ||
        early !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL chain_result: rs=%0d p1=%h p3=%h early=%b tmo=%b busy=%b done=%b want 3 ff9911 ff9918 0 0 0 0",
               res_stage, res_para1, res_para3, early, timeout, busy, done);
    else pass_cnt++;
  endtask

  task automatic test_early();
    set_comb(32'h11, 32'h22, 32'h33);
    zero[1] = 1'b1;
    p1[1] = 32'h123;
    model();
    run_collect(-1, -1);
    total_cnt++;
    if (obs_done !== 4) $display("[TB] FAIL early_done_cycle: got %0d want 4", obs_done);
    else pass_cnt++;
    for (int k = 0; k < obs_en.size(); k++) begin
      total_cnt++;
      if (obs_en[k][2] !== 1'b0 || (k < exp_en.size() && obs_en[k] !== exp_en[k]))
        $display("[TB] FAIL early_en cycle %0d: got %b", k + 1, obs_en[k]);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (early !== 1'b1 || timeout !== 1'b0 || res_stage !== 2'd1 || res_para1 !== 32'h123)
      $display("[TB] FAIL early_result: early=%b tmo=%b rs=%0d p1=%h want 1 0 1 123",
               early, timeout, res_stage, res_para1);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    for (int i = 0; i < NSTAGE; i++) begin
      lat[i] = 1; zero[i] = 1'b0;
      p1[i] = 32'h100 + i; p2[i] = 32'h200 + i; p3[i] = 32'h300 + i;
    end
    lat[2] = 1000;
    model();
    run_collect(-1, -1);
    total_cnt++;
    if (obs_done !== exp_done) $display("[TB] FAIL tmo_done_cycle: got %0d want %0d", obs_done, exp_done);
    else pass_cnt++;
    for (int k = 0; k < exp_en.size() && k < obs_en.size(); k++) begin
      total_cnt++;
      if (obs_en[k] !== exp_en[k])
        $display("[TB] FAIL tmo_en cycle %0d: got %b want %b", k + 1, obs_en[k], exp_en[k]);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (timeout !== 1'b1 || early !== 1'b0 || res_stage !== 2'd2 ||
        res_para1 !== 32'h101 || res_para2 !== 32'h201 || res_para3 !== 32'h301)
      $display("[TB] FAIL tmo_result: tmo=%b early=%b rs=%0d p=%h/%h/%h want 1 0 2 101/201/301",
               timeout, early, res_stage, res_para1, res_para2, res_para3);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    set_comb(32'haa, 32'hbb, 32'hcc);
    lat[0] = 3;
    run_collect(2, -1);
    total_cnt++;
    if (obs_en.size() < 3 || obs_en[0] !== 4'b0001 || obs_en[1] !== 4'b0001 ||
        obs_en[2] !== 4'b0000 || obs_busy[2] !== 1'b0 || obs_done !== -1)
      $display("[TB] FAIL abort_stop: en3=%b busy3=%b done_at=%0d want 0000 0 -1",
               obs_en[2], obs_busy[2], obs_done);
    else pass_cnt++;
    total_cnt++;
    if (timeout !== 1'b0 || early !== 1'b0 || res_para1 !== 32'h0)
      $display("[TB] FAIL abort_flags: tmo=%b early=%b p1=%h want 0 0 0", timeout, early, res_para1);
    else pass_cnt++;
    // End and abort land in the same cycle: nothing may be captured
    lat[0] = 1;
    run_collect(2, -1);
    total_cnt++;
    if (res_para1 !== 32'h0 || obs_done !== -1 || busy !== 1'b0)
      $display("[TB] FAIL abort_vs_end: p1=%h done_at=%0d busy=%b want 0 -1 0", res_para1, obs_done, busy);
    else pass_cnt++;
    lat[0] = 0;
    model();
    run_collect(-1, -1);
    total_cnt++;
    if (obs_en[0] !== 4'b0001 || obs_done !== exp_done)
      $display("[TB] FAIL abort_restart: en1=%b done_at=%0d want 0001 %0d", obs_en[0], obs_done, exp_done);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_ignored_inputs();
    for (int i = 0; i < NSTAGE; i++) begin
      lat[i] = 1; zero[i] = 1'b0; p1[i] = 32'h500 + i; p2[i] = 32'h600; p3[i] = 32'h700;
    end
    model();
    run_collect(-1, 3);
    total_cnt++;
    if (obs_done !== exp_done || res_stage !== 2'd3 || res_para1 !== 32'h503)
      $display("[TB] FAIL start_while_busy: done_at=%0d rs=%0d p1=%h want %0d 3 503",
               obs_done, res_stage, res_para1, exp_done);
    else pass_cnt++;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || stage_en !== '0 || res_para1 !== 32'h503)
      $display("[TB] FAIL start_with_abort: busy=%b en=%b p1=%h want 0 0000 503", busy, stage_en, res_para1);
    else pass_cnt++;
    set_comb(32'h77, 32'h88, 32'h99);
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({stage_en, stage_idx, busy, done, early, timeout, res_stage} !== '0 ||
        {res_para1, res_para2, res_para3} !== '0)
      $display("[TB] FAIL reset_mid_run: en=%b idx=%0d busy=%b p1=%h want all 0",
               stage_en, stage_idx, busy, res_para1);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < NSTAGE; i++) begin
        lat[i]  = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
        zero[i] = ($urandom_range(0, 5) == 0);
        p1[i] = $urandom; p2[i] = $urandom; p3[i] = $urandom;
      end
      model();
      run_collect(-1, -1);
      total_cnt++;
      if (obs_done !== exp_done)
        $display("[TB] FAIL rand%0d_done_cycle: got %0d want %0d", it, obs_done, exp_done);
      else pass_cnt++;
      for (int k = 0; k < exp_en.size() && k < obs_en.size(); k++) begin
        total_cnt++;
        if (obs_en[k] !== exp_en[k])
          $display("[TB] FAIL rand%0d_en cycle %0d: got %b want %b", it, k + 1, obs_en[k], exp_en[k]);
        else pass_cnt++;
      end
      @(negedge clk);
      total_cnt++;
      if (early !== exp_early || timeout !== exp_tmo || res_stage !== exp_stage ||
          res_para1 !== exp_p1 || res_para2 !== exp_p2 || res_para3 !== exp_p3 || busy !== 1'b0)
        $display("[TB] FAIL rand%0d_result: e=%b t=%b rs=%0d p=%h/%h/%h want e=%b t=%b rs=%0d p=%h/%h/%h",
                 it, early, timeout, res_stage, res_para1, res_para2, res_para3,
                 exp_early, exp_tmo, exp_stage, exp_p1, exp_p2, exp_p3);
      else pass_cnt++;
    end
  endtask

  initial begin
    set_comb(32'h0, 32'h0, 32'h0);
    test_reset();
    test_chain();
    test_early();
    test_timeout();
    test_abort();
    test_ignored_inputs();
    @(negedge clk);
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dmn_seq.md
# dmn_seq

Sequencer for the chain of `dmn_*` parameter stages in the QR datapath. On `start` it walks stages 0..NSTAGE-1 in order, raising each stage's enable and waiting for its end. It captures the selected stage's three 32-bit parameters, stops early when a stage flags `zero`, and guards every stage with a timeout. It sits between the top-level control FSM and the stage bank; an external mux driven by `stage_idx` presents the selected stage's outputs on `para_in*` and `stage_end`/`stage_zero`.

## Interface
- `NSTAGE`, 4 — number of stages sequenced (2..8)
- `IW`, 2 — width of stage index, ≥ clog2(NSTAGE)
- `TIMEOUT`, 1024 — max RUN cycles per stage before error (≥2)
- `TW`, 16 — timeout counter width, 2^TW > TIMEOUT

- `clk` in 1 — single clock, all logic rising-edge
- `rst` in 1 — synchronous, active-high reset
- `start` in 1 — begin sequence; honoured only in IDLE
- `abort` in 1 — cancel sequence, return to IDLE, no `done`
- `stage_en` out NSTAGE — one-hot enable to stage `stage_idx`, else 0
- `stage_idx` out IW — index of stage currently addressed
- `stage_end` in 1 — end of addressed stage (may be combinational from its enable)
- `stage_zero` in 1 — zero flag of addressed stage
- `para_in1`/`para_in2`/`para_in3` in 32 each — addressed stage's parameters
- `busy` out 1 — high in RUN and GAP
- `done` out 1 — one-cycle pulse at sequence completion (normal, early or timeout)
- `early` out 1 — sticky: sequence stopped on `stage_zero`
- `timeout` out 1 — sticky: a stage failed to end within TIMEOUT cycles
- `res_stage` out IW — index of last stage ended (or timed out)
- `res_para1`/`res_para2`/`res_para3` out 32 each — parameters captured at last stage end

## Operation
- States: IDLE, RUN, GAP, DONE.
- IDLE: all `stage_en`=0, `busy`=0. Results and flags hold. On `start`=1 and `abort`=0: clear `early`, `timeout`, `res_*`; set `stage_idx`=0, counter=0; go to RUN.
- RUN: `stage_en`=1<<`stage_idx`. Sample `stage_end` every cycle, including the first.
  - If `stage_end`=1: capture `para_in1..3` into `res_para1..3` and `stage_idx` into `res_stage`.
    - If `stage_zero`=1: set `early`, go to DONE.
    - Else if `stage_idx`=NSTAGE-1: go to DONE.
    - Else: go to GAP.
  - Else if counter = TIMEOUT-1: set `timeout`, set `res_stage`=`stage_idx`, leave `res_para*` unchanged, go to DONE.
  - Else: counter+1.
- GAP: `stage_en`=0 for exactly one cycle. `stage_idx`+1, counter=0, go to RUN. This guarantees every enable has a falling edge between stages.
- DONE: `done`=1, `stage_en`=0, `busy`=0; next state IDLE unconditionally.
- `abort`=1 in RUN or GAP: next state IDLE, `stage_en`=0 next cycle, no `done`, flags and results keep their current values. `abort` in IDLE/DONE has no effect, except that it blocks a same-cycle `start`.
- `start` outside IDLE is ignored (no queuing).
- Simultaneous `stage_end`=1 and counter=TIMEOUT-1: end wins, no timeout.
- Simultaneous `stage_end`=1 and `abort`=1: abort wins; nothing is captured.

## Timing
- Reset: state IDLE. `stage_en`, `stage_idx`, `busy`, `done`, `early`, `timeout`, `res_stage`, `res_para*` and counter all 0.
- `rst` mid-sequence: the next edge forces the reset values; any stage in progress is dropped.
- All outputs are registered. `stage_en` rises on the edge after `start`, or after GAP.
- Combinational stage (end same cycle as en): 1 RUN + 1 GAP = 2 cycles per stage. The last stage takes 1 RUN then DONE.
- Full chain of combinational stages: `start` sampled at edge 0; `done` high during cycle 2·NSTAGE; back in IDLE the cycle after.
- Timeout: `done` asserts in the cycle after the TIMEOUT-th RUN cycle of the stuck stage.
- `res_*`, `early`, `timeout` are valid from the `done` cycle until the cycle after the next accepted `start`.

## Test plan
- NSTAGE=4, all stages `stage_end`=`stage_en` (combinational), para = 0xff9911/2/8, zero=0, `start` at cycle 0 -> `stage_en` 0001, 0000, 0010, 0000, 0100, 0000, 1000; `done` at cycle 8; `res_stage`=3, `res_para1`=0xff9911, `early`=0, `timeout`=0.
- Stage 1 returns `stage_zero`=1 with para1=0x123 -> `done` at cycle 4, `early`=1, `res_stage`=1, `res_para1`=0x123; `stage_en[2]` never asserts.
- TIMEOUT=8, stage 2 never ends -> `stage_en`=0100 for exactly 8 cycles; then `done`=1, `timeout`=1, `res_stage`=2; `res_para*` still hold stage 1 values.
- Stage 0 ends 3 cycles after enable, with `abort` pulsed in its 2nd RUN cycle -> `stage_en`=0 next cycle, state IDLE, no `done`; a new `start` 2 cycles later restarts at stage 0 and clears the flags.
- `start` pulsed while `busy`=1, and `start`+`abort` together in IDLE -> both ignored; `rst` asserted mid-RUN -> all outputs 0 on the next cycle.
